decoder_5_to_32_stream: RTL and testbench

- Streaming inverse of the 32-to-5 encoder: accepts 5-bit codes on a valid/ready input and produces registered 32-bit one-hot (or thermometer) words on a valid/ready output.
- A 2-entry elastic buffer decouples the two sides so back-to-back codes flow at one per clock.
- A free-running count of delivered words supports bring-up and loop-back checks against the encoder.

---
 rtl/dec_pkg.sv | 23 ++
 rtl/decoder_5_to_32_stream_if.sv | 25 ++
 rtl/dec_skid_buf.sv | 98 +++++++++
 rtl/decoder_5_to_32_stream.sv | 48 ++++
 tb/tb_decoder_5_to_32_stream.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// Shared widths, occupancy states and the code-to-word decode for the
// 5-to-32 streaming decoder.
package dec_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // One-hot: 1 << code.  Thermometer: (2 << code) - 1 in WORD_W+1 bits, truncated.
  function automatic logic [WORD_W-1:0] decode_word(input logic [CODE_W-1:0] code,
                                                     input logic              thermo);
    logic [WORD_W:0] w_t;
    w_t = (WORD_W+1)'(2) << code;
    if (thermo) return WORD_W'(w_t - (WORD_W+1)'(1));
    return WORD_W'(1) << code;
  endfunction

endpackage

// File: rtl/decoder_5_to_32_stream_if.sv
// Valid/ready code input and decoded word output of the streaming decoder.
interface decoder_5_to_32_stream_if;
  import dec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_thermo;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_code, in_thermo, out_ready,
    input  in_ready, out_valid, out_word
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_code, in_thermo, out_ready,
    output in_ready, out_valid, out_word
  );

endinterface

// File: rtl/dec_skid_buf.sv
// Two-entry elastic buffer with registered ready/valid; head entry drives the
// output and reads zero whenever the buffer is empty.
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  occ_t              r_state;
  occ_t              w_state_nxt;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [DATA_W-1:0] w_head_nxt;
  logic [DATA_W-1:0] w_tail_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_in_ready_nxt;
  logic              w_out_valid_nxt;
  logic              w_acc;
  logic              w_dlv;

  assign w_acc = i_valid && r_in_ready;
  assign w_dlv = r_out_valid && i_ready;

  // State, entries and handshake flags all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_head      <= '0;
      r_tail      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Occupancy transitions; ready/valid are precomputed from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;

    unique case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_state_nxt = ONE;
          w_head_nxt  = i_data;
        end
      end
      ONE: begin
        if (w_acc && w_dlv) begin
          w_head_nxt = i_data;
        end else if (w_acc) begin
          w_state_nxt = FULL;
          w_tail_nxt  = i_data;
        end else if (w_dlv) begin
          w_state_nxt = EMPTY;
          w_head_nxt  = '0;
        end
      end
      FULL: begin
        // in_ready is low here, so only a delivery can happen.
        if (w_dlv) begin
          w_state_nxt = ONE;
          w_head_nxt  = r_tail;
          w_tail_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_head_nxt  = '0;
        w_tail_nxt  = '0;
      end
    endcase

    w_in_ready_nxt  = (w_state_nxt != FULL);
    w_out_valid_nxt = (w_state_nxt != EMPTY);
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_head;

endmodule

// File: rtl/decoder_5_to_32_stream.sv
// Streaming 5-to-32 decoder: decodes codes at acceptance into a two-entry
// buffer and counts completed output handshakes.
module decoder_5_to_32_stream
  import dec_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  decoder_5_to_32_stream_if.slave  bus,
  output logic [CNT_W-1:0]         dec_count
);

  logic [WORD_W-1:0] w_word;
  logic [CNT_W-1:0]  r_dec_count;

  if (DEPTH != 2) begin : g_depth_chk
    $error("decoder_5_to_32_stream: only DEPTH=2 is implemented");
  end

  assign w_word = decode_word(bus.in_code, bus.in_thermo);

  dec_skid_buf #(
    .DATA_W (WORD_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  (w_word),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (bus.out_word)
  );

  // Free-running delivered-word count, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      r_dec_count <= r_dec_count + CNT_W'(1);
    end
  end

  assign dec_count = r_dec_count;

endmodule

// File: tb/tb_decoder_5_to_32_stream.sv
// Directed bench for decoder_5_to_32_stream with an in-order scoreboard.
module tb_decoder_5_to_32_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] dec_count;
  logic [3:0]  dec_count2;

  int          n_tests;
  int          n_fail;
  logic [31:0] sb[$];

  decoder_5_to_32_stream_if bus ();
  decoder_5_to_32_stream_if bus2 ();

  decoder_5_to_32_stream #(.DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dec_count (dec_count)
  );

  decoder_5_to_32_stream #(.DEPTH(2), .CNT_W(4)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus2),
    .dec_count (dec_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written bit by bit.
  function automatic logic [31:0] tb_decode(input logic [4:0] code, input logic thermo);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[b] = thermo ? (b <= int'(code)) : (b == int'(code));
    return w;
  endfunction

  // Reference 32-to-5 encoder for loop-back.
  function automatic logic [31:0] tb_encode(input logic [31:0] w);
    logic [31:0] r;
    r = 32'hDEAD;
    for (int b = 0; b < 32; b++) if (w[b]) r = 32'(b);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: score the handshakes of the coming edge, then advance.
  task automatic tick();
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_underflow: observed %h expected none", bus.out_word);
      end else begin
        check("sb_word", bus.out_word, sb.pop_front());
      end
    end
    if (bus.in_valid && bus.in_ready) sb.push_back(tb_decode(bus.in_code, bus.in_thermo));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_code    = '0;
    bus.in_thermo  = 1'b0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_code   = '0;
    bus2.in_thermo = 1'b0;
    bus2.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_word", bus.out_word, 32'h0);
    check("rst_dec_count", 32'(dec_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // One-hot sweep at full rate.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = 5'(c);
      check("sweep_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("sweep_latency", bus.out_word, 32'h1 << c);
    end
    bus.in_valid = 1'b0;
    tick();
    check("sweep_count", 32'(dec_count), 32'd32);
    check("sweep_empty_valid", 32'(bus.out_valid), 32'd0);
    check("sweep_empty_word", bus.out_word, 32'h0);

    // Thermometer corners.
    bus.in_thermo = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_code   = 5'd0;
    tick();
    check("thermo_0", bus.out_word, 32'h0000_0001);
    bus.in_code = 5'd4;
    tick();
    check("thermo_4", bus.out_word, 32'h0000_001F);
    bus.in_code = 5'd31;
    tick();
    check("thermo_31", bus.out_word, 32'hFFFF_FFFF);
    bus.in_valid  = 1'b0;
    bus.in_thermo = 1'b0;
    tick();

    // Backpressure into FULL, stalled offer, then release.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_code   = 5'd3;
    tick();
    bus.in_code = 5'd7;
    tick();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_word", bus.out_word, 32'h8);
    bus.in_code = 5'd9;
    tick();
    bus.in_code = 5'd12;
    tick();
    bus.in_code = 5'd9;
    check("stall_word", bus.out_word, 32'h8);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("release_1", bus.out_word, 32'h80);
    tick();
    check("release_2", bus.out_word, 32'h200);
    bus.in_valid = 1'b0;
    tick();
    check("release_empty", 32'(bus.out_valid), 32'd0);
    check("release_count", 32'(dec_count), 32'd38);

    // Accept and deliver together while holding one word.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_code   = 5'd10;
    tick();
    check("one_valid", 32'(bus.out_valid), 32'd1);
    bus.in_code   = 5'd11;
    bus.out_ready = 1'b1;
    tick();
    check("both_valid", 32'(bus.out_valid), 32'd1);
    check("both_in_ready", 32'(bus.in_ready), 32'd1);
    check("both_word", bus.out_word, 32'h800);
    bus.in_valid = 1'b0;
    tick();
    check("both_count", 32'(dec_count), 32'd40);

    // Mid-stream asynchronous reset from FULL.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_code   = 5'd1;
    tick();
    bus.in_code = 5'd2;
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_full", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_word", bus.out_word, 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_count", 32'(dec_count), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_code   = 5'd5;
    tick();
    check("post_rst_word", bus.out_word, 32'h20);
    bus.in_valid = 1'b0;
    tick();

    // 17 handshakes through the 4-bit counter instance.
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_code  = 5'(i);
      tick();
    end
    bus2.in_valid = 1'b0;
    tick();
    check("wrap_count", 32'(dec_count2), 32'd1);

    // Loop-back through the reference encoder.
    for (int c = 0; c < 32; c++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = 5'(c);
      tick();
      check("loopback", tb_encode(bus.out_word), 32'(c));
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("final_count", 32'(dec_count), 32'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
